alarm_buzzer_sequencer: RTL



---
 rtl/alarm_buzzer_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alarm_buzzer_sequencer.sv
// Alarm buzzer sequencer: gated square-wave beep cadence with timeout, cancel and re-trigger lockout.
// Optional snooze support is built when the macro ALARM_SNOOZE_EN is defined.
module alarm_buzzer_sequencer #(
   parameter int unsigned TONE_HALF     = 5000,
   parameter int unsigned BEEP_ON_CYC   = 15_750_000,
   parameter int unsigned BEEP_OFF_CYC  = 15_750_000,
   parameter int unsigned TIMEOUT_BEEPS = 120,
   parameter int unsigned SNOOZE_CYC    = 32'd283_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       alarm_trig,
   input  logic       alarm_cancel,
   input  logic       snooze_pulse,
   output logic       buzzer_out,
   output logic       ringing,
   output logic       snoozing,
   output logic [2:0] state_o
);

   localparam int unsigned PH_MAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
   localparam int unsigned PW = $clog2(PH_MAX + 1);
   localparam int unsigned TW = $clog2(TONE_HALF + 1);
   localparam int unsigned BW = $clog2(TIMEOUT_BEEPS + 1);

   localparam logic [PW-1:0] ON_LAST   = PW'(BEEP_ON_CYC - 1);
   localparam logic [PW-1:0] OFF_LAST  = PW'(BEEP_OFF_CYC - 1);
   localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
   localparam logic [BW-1:0] BEEP_LAST = BW'(TIMEOUT_BEEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_BEEP_ON  = 3'd1,
      S_BEEP_OFF = 3'd2,
      S_LOCKOUT  = 3'd3
`ifdef ALARM_SNOOZE_EN
      , S_SNOOZE = 3'd4
`endif
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          tone_q, tone_d;
   logic [BW-1:0] beep_q, beep_d;
   logic          buzzer_q, ringing_q, snoozing_q;
   logic          beeping, active;

`ifdef ALARM_SNOOZE_EN
   localparam int unsigned SW = $clog2(SNOOZE_CYC + 1);
   localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_CYC - 1);
   logic [SW-1:0] snz_q, snz_d;
   assign active = beeping || (state_q == S_SNOOZE);
`else
   logic unused_snooze;
   assign unused_snooze = snooze_pulse;
   assign active = beeping;
`endif

   assign beeping = (state_q == S_BEEP_ON) || (state_q == S_BEEP_OFF);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      tcnt_d  = tcnt_q;
      tone_d  = tone_q;
      beep_d  = beep_q;
`ifdef ALARM_SNOOZE_EN
      snz_d   = snz_q;
`endif
      // Cancel outranks snooze; both only act while the alarm sequence is live.
      if (active && alarm_cancel) begin
         state_d = S_LOCKOUT;
         phase_d = '0;
         tcnt_d  = '0;
         tone_d  = 1'b0;
         beep_d  = '0;
`ifdef ALARM_SNOOZE_EN
         snz_d   = '0;
      end else if (beeping && snooze_pulse) begin
         state_d = S_SNOOZE;
         phase_d = '0;
         tcnt_d  = '0;
         tone_d  = 1'b0;
         snz_d   = '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               phase_d = '0;
               tcnt_d  = '0;
               tone_d  = 1'b0;
               beep_d  = '0;
               if (alarm_trig) state_d = S_BEEP_ON;
            end
            S_BEEP_ON: begin
               if (tcnt_q == TONE_LAST) begin
                  tcnt_d = '0;
                  tone_d = ~tone_q;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
               if (phase_q == ON_LAST) begin
                  state_d = S_BEEP_OFF;
                  phase_d = '0;
                  tcnt_d  = '0;
                  tone_d  = 1'b0;
               end else begin
                  phase_d = phase_q + PW'(1);
               end
            end
            S_BEEP_OFF: begin
               if (phase_q == OFF_LAST) begin
                  phase_d = '0;
                  if (beep_q == BEEP_LAST) begin
                     state_d = S_LOCKOUT;
                     beep_d  = '0;
                  end else begin
                     state_d = S_BEEP_ON;
                     beep_d  = beep_q + BW'(1);
                  end
               end else begin
                  phase_d = phase_q + PW'(1);
               end
            end
`ifdef ALARM_SNOOZE_EN
            S_SNOOZE: begin
               if (snz_q == SNZ_LAST) begin
                  state_d = S_BEEP_ON;
                  snz_d   = '0;
                  beep_d  = '0;
               end else begin
                  snz_d = snz_q + SW'(1);
               end
            end
`endif
            S_LOCKOUT: begin
               phase_d = '0;
               tcnt_d  = '0;
               tone_d  = 1'b0;
               beep_d  = '0;
               // The trigger flag stays high for the whole matching minute; wait for it to drop.
               if (!alarm_trig) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         tcnt_q     <= '0;
         tone_q     <= 1'b0;
         beep_q     <= '0;
         buzzer_q   <= 1'b0;
         ringing_q  <= 1'b0;
         snoozing_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         snz_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         tcnt_q     <= tcnt_d;
         tone_q     <= tone_d;
         beep_q     <= beep_d;
         buzzer_q   <= (state_d == S_BEEP_ON) && tone_d;
         ringing_q  <= (state_d == S_BEEP_ON) || (state_d == S_BEEP_OFF);
`ifdef ALARM_SNOOZE_EN
         snz_q      <= snz_d;
         snoozing_q <= (state_d == S_SNOOZE);
`else
         snoozing_q <= 1'b0;
`endif
      end
   end

   assign buzzer_out = buzzer_q;
   assign ringing    = ringing_q;
   assign snoozing   = snoozing_q;
   assign state_o    = state_q;

endmodule
